// File: rtl/ex_dmem_req.sv
// ex_dmem_req: EX-side data-memory request unit.
// Turns an EX-stage load/store into a req/addr_ok/data_ok transaction on a
// variable-latency data SRAM. It generates the MEM byte-lane select and
// holds the returned read data while the pipeline is stalled.
//
// Optional feature: define DMEM_ALIGN_CHK_EN to reject misaligned half/word
// accesses with an adexc pulse instead of issuing them.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   stall[5:0]            pipeline stall vector (stall[3] holds EX)
//   mem_en/we/size/addr/wdata   EX-stage access description
//   data_sram_*           SRAM request (out) and handshake/response (in)
//   data_ram_sel          byte-lane select for MEM load extraction
//   rdata_hold            captured read data for MEM
//   stallreq              combinational pipeline hold while the access is in flight
//   err                   one-cycle watchdog-timeout pulse
//   adexc                 misaligned-address flag (combinational, IDLE cycle)
module ex_dmem_req #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        mem_en,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [3:0]  data_sram_wen,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic [3:0]  data_ram_sel,
   output logic [31:0] rdata_hold,
   output logic        stallreq,
   output logic        err,
   output logic        adexc
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_q;

   logic [3:0]    sel_c;
   logic [31:0]   wdata_c;
   logic          misalign_c;
   logic          issue_c;
   logic          timeout_c;

   // Only stall[3] concerns this stage.
   logic unused_stall;
   assign unused_stall = &{1'b0, stall[5:4], stall[2:0]};

   // Byte-lane select and lane-replicated store data for the EX access.
   always_comb begin
      sel_c   = 4'b1111;
      wdata_c = mem_wdata;
      case (mem_size)
         2'b00: begin
            sel_c   = 4'b0001 << mem_addr[1:0];
            wdata_c = {4{mem_wdata[7:0]}};
         end
         2'b01: begin
            sel_c   = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{mem_wdata[15:0]}};
         end
         default: begin
            sel_c   = 4'b1111;
            wdata_c = mem_wdata;
         end
      endcase
   end

`ifdef DMEM_ALIGN_CHK_EN
   assign misalign_c = ((mem_size == 2'b01) & mem_addr[0]) |
                       (mem_size[1] & (|mem_addr[1:0]));
   assign adexc      = (state == IDLE) & mem_en & misalign_c;
`else
   assign misalign_c = 1'b0;
   assign adexc      = 1'b0;
`endif

   assign issue_c   = (state == IDLE) & mem_en & ~misalign_c;
   assign timeout_c = (cnt == CW'(MAX_WAIT - 1));
   assign stallreq  = issue_c | (state == REQ) | (state == WAIT);

   // Access FSM with registered SRAM request, lane select and read-data hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         we_q            <= 1'b0;
         data_sram_req   <= 1'b0;
         data_sram_wr    <= 1'b0;
         data_sram_wen   <= 4'b0000;
         data_sram_addr  <= 32'h0;
         data_sram_wdata <= 32'h0;
         data_ram_sel    <= 4'b0000;
         rdata_hold      <= 32'h0;
         err             <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (issue_c) begin
                  cnt             <= '0;
                  we_q            <= mem_we;
                  data_sram_req   <= 1'b1;
                  data_sram_wr    <= mem_we;
                  data_sram_wen   <= mem_we ? sel_c : 4'b0000;
                  data_sram_addr  <= mem_addr;
                  data_sram_wdata <= wdata_c;
                  data_ram_sel    <= sel_c;
                  state           <= REQ;
               end
            end
            REQ: begin
               cnt <= cnt + CW'(1);
               if (data_sram_addr_ok & data_sram_data_ok) begin
                  data_sram_req <= 1'b0;
                  data_sram_wr  <= 1'b0;
                  data_sram_wen <= 4'b0000;
                  if (!we_q) rdata_hold <= data_sram_rdata;
                  state <= DONE;
               end else if (timeout_c) begin
                  // Watchdog abort: withdraw the request and hand MEM zeros.
                  err           <= 1'b1;
                  rdata_hold    <= 32'h0;
                  data_sram_req <= 1'b0;
                  data_sram_wr  <= 1'b0;
                  data_sram_wen <= 4'b0000;
                  state         <= DONE;
               end else if (data_sram_addr_ok) begin
                  data_sram_req <= 1'b0;
                  data_sram_wr  <= 1'b0;
                  data_sram_wen <= 4'b0000;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + CW'(1);
               if (data_sram_data_ok) begin
                  if (!we_q) rdata_hold <= data_sram_rdata;
                  state <= DONE;
               end else if (timeout_c) begin
                  err        <= 1'b1;
                  rdata_hold <= 32'h0;
                  state      <= DONE;
               end
            end
            DONE: begin
               // Another stage may still hold EX; keep results until released.
               if (!stall[3]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_dmem_req.sv
// Self-checking bench for ex_dmem_req: directed scenarios plus randomized
// accesses checked against a transaction-level reference model.
module tb_ex_dmem_req;

   localparam int unsigned MAX_WAIT = 8;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        mem_en;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [3:0]  data_ram_sel;
   logic [31:0] rdata_hold;
   logic        stallreq;
   logic        err;
   logic        adexc;

   int checks;
   int errors;
   logic [31:0] model_hold;

   ex_dmem_req #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .mem_en            (mem_en),
      .mem_we            (mem_we),
      .mem_size          (mem_size),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_wen     (data_sram_wen),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .data_ram_sel      (data_ram_sel),
      .rdata_hold        (rdata_hold),
      .stallreq          (stallreq),
      .err               (err),
      .adexc             (adexc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: an access touches n = 1/2/4 bytes starting at the
   // n-aligned offset within the word.
   function automatic int unsigned access_bytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [31:0] addr);
      int unsigned n;
      int unsigned first;
      n     = access_bytes(size);
      first = (int'(addr % 4) / n) * n;
      return 4'(((1 << n) - 1) << first);
   endfunction

   // Each lane i carries store byte (i mod n).
   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      int unsigned n;
      n = access_bytes(size);
      r = 32'h0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   // One full access: a = extra cycles before addr_ok, d = cycles from
   // addr_ok to data_ok (0 = same cycle), hold = DONE cycles with stall[3]=1.
   task automatic run_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input int a, input int d, input int hold,
                             input logic [31:0] rd);
      logic [3:0]  esel;
      logic [3:0]  ewen;
      logic [31:0] ewd;
      esel = model_sel(size, addr);
      ewen = we ? esel : 4'b0000;
      ewd  = model_wdata(size, wd);
      @(posedge clk); #1;
      mem_en = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wd;
      stall = 6'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      @(negedge clk);
      checks++;
      if (stallreq !== 1'b1 || data_sram_req !== 1'b0 || adexc !== 1'b0) begin
         errors++;
         $display("FAIL issue_cycle addr=%h: stallreq=%b req=%b adexc=%b, required 1 0 0",
                  addr, stallreq, data_sram_req, adexc);
      end
      for (int c = 1; c <= 1 + a + d; c++) begin
         @(posedge clk); #1;
         data_sram_addr_ok = (c == 1 + a);
         data_sram_data_ok = (c == 1 + a + d);
         data_sram_rdata   = (c == 1 + a + d) ? rd : $urandom;
         @(negedge clk);
         checks++;
         if (stallreq !== 1'b1) begin
            errors++;
            $display("FAIL inflight_stallreq cyc=%0d: got %b, required 1", c, stallreq);
         end
         checks++;
         if (c <= 1 + a) begin
            if ({data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata} !==
                {1'b1, we, ewen, addr, ewd}) begin
               errors++;
               $display("FAIL request_fields cyc=%0d: req=%b wr=%b wen=%b addr=%h wdata=%h, required 1 %b %b %h %h",
                        c, data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata,
                        we, ewen, addr, ewd);
            end
         end else if (data_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL req_after_accept cyc=%0d: got %b, required 0", c, data_sram_req);
         end
      end
      if (!we) model_hold = rd;
      for (int h = 0; h <= hold; h++) begin
         @(posedge clk); #1;
         mem_en = 1'b0; data_sram_addr_ok = 1'b0;
         data_sram_data_ok = 1'b1;              // stray response, must be ignored
         data_sram_rdata   = $urandom;
         stall = (h < hold) ? 6'b001000 : 6'b000000;
         @(negedge clk);
         checks++;
         if (stallreq !== 1'b0 || data_ram_sel !== esel || rdata_hold !== model_hold ||
             data_sram_req !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL done_hold h=%0d: stallreq=%b sel=%b rdata_hold=%h req=%b err=%b, required 0 %b %h 0 0",
                     h, stallreq, data_ram_sel, rdata_hold, data_sram_req, err, esel, model_hold);
         end
      end
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0; stall = 6'b0;
      @(negedge clk);
      checks++;
      if (stallreq !== 1'b0 || data_sram_req !== 1'b0 || rdata_hold !== model_hold) begin
         errors++;
         $display("FAIL back_to_idle: stallreq=%b req=%b rdata_hold=%h, required 0 0 %h",
                  stallreq, data_sram_req, rdata_hold, model_hold);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 6'b0; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'b00;
      mem_addr = 32'h0; mem_wdata = 32'h0; data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      model_hold = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata,
           data_ram_sel, rdata_hold, stallreq, err, adexc} !== 110'b0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b wr=%b wen=%b addr=%h wdata=%h sel=%b hold=%h stallreq=%b err=%b adexc=%b, required all 0",
                  data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata,
                  data_ram_sel, rdata_hold, stallreq, err, adexc);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_load_word();
      run_access(1'b0, 2'b10, 32'h0000_0100, 32'h0, 0, 2, 0, 32'hDEAD_BEEF);
      checks++;
      if (rdata_hold !== 32'hDEAD_BEEF || data_ram_sel !== 4'b1111) begin
         errors++;
         $display("FAIL lw_result: rdata_hold=%h sel=%b, required deadbeef 1111", rdata_hold, data_ram_sel);
      end
   endtask

   task automatic test_store_byte();
      run_access(1'b1, 2'b00, 32'h0000_0203, 32'h0000_005A, 1, 1, 0, 32'h1111_2222);
      checks++;
      if (rdata_hold !== 32'hDEAD_BEEF || data_ram_sel !== 4'b1000) begin
         errors++;
         $display("FAIL sb_result: rdata_hold=%h sel=%b, required deadbeef 1000", rdata_hold, data_ram_sel);
      end
   endtask

   task automatic test_half_same_cycle();
      run_access(1'b0, 2'b01, 32'h0000_0102, 32'h0, 0, 0, 0, 32'hCAFE_F00D);
   endtask

   task automatic test_done_stall();
      run_access(1'b0, 2'b10, 32'h0000_0400, 32'h0, 2, 1, 3, 32'h1234_ABCD);
   endtask

   task automatic test_watchdog();
      @(posedge clk); #1;
      mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_0300;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; stall = 6'b0;
      @(negedge clk);
      for (int c = 1; c <= int'(MAX_WAIT); c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (data_sram_req !== 1'b1 || stallreq !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL wd_waiting cyc=%0d: req=%b stallreq=%b err=%b, required 1 1 0",
                     c, data_sram_req, stallreq, err);
         end
      end
      @(posedge clk); #1;
      mem_en = 1'b0;
      @(negedge clk);
      model_hold = 32'h0;
      checks++;
      if (err !== 1'b1 || data_sram_req !== 1'b0 || stallreq !== 1'b0 || rdata_hold !== 32'h0) begin
         errors++;
         $display("FAIL wd_abort: err=%b req=%b stallreq=%b rdata_hold=%h, required 1 0 0 0",
                  err, data_sram_req, stallreq, rdata_hold);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || stallreq !== 1'b0) begin
         errors++;
         $display("FAIL wd_pulse_end: err=%b stallreq=%b, required 0 0", err, stallreq);
      end
   endtask

   task automatic test_misaligned();
`ifdef DMEM_ALIGN_CHK_EN
      @(posedge clk); #1;
      mem_en = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h0000_0101; mem_wdata = 32'hA5A5_0001;
      @(negedge clk);
      checks++;
      if (adexc !== 1'b1 || stallreq !== 1'b0) begin
         errors++;
         $display("FAIL misalign_flag: adexc=%b stallreq=%b, required 1 0", adexc, stallreq);
      end
      @(posedge clk); #1;
      mem_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (data_sram_req !== 1'b0 || adexc !== 1'b0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL misalign_no_req cyc=%0d: req=%b adexc=%b stallreq=%b, required 0 0 0",
                     c, data_sram_req, adexc, stallreq);
         end
      end
`else
      run_access(1'b1, 2'b10, 32'h0000_0101, 32'hA5A5_0001, 0, 1, 0, 32'h0);
      checks++;
      if (data_ram_sel !== 4'b1111) begin
         errors++;
         $display("FAIL sw_unaligned_sel: got %b, required 1111", data_ram_sel);
      end
`endif
   endtask

   task automatic test_reset_mid_access();
      @(posedge clk); #1;
      mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_0500;
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b1;
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0; mem_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_hold = 32'h0;
      checks++;
      if (stallreq !== 1'b0 || data_sram_req !== 1'b0 || rdata_hold !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: stallreq=%b req=%b rdata_hold=%h, required 0 0 0",
                  stallreq, data_sram_req, rdata_hold);
      end
      @(posedge clk); #1;
      rst = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
      @(negedge clk);
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
      @(negedge clk);
      checks++;
      if (rdata_hold !== 32'h0 || stallreq !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL late_response: rdata_hold=%h stallreq=%b err=%b, required 0 0 0",
                  rdata_hold, stallreq, err);
      end
   endtask

   task automatic test_random();
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      for (int i = 0; i < 30; i++) begin
         we   = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = $urandom;
`ifdef DMEM_ALIGN_CHK_EN
         if (size != 2'b00) addr = addr & ((size == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
`endif
         run_access(we, size, addr, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), $urandom);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load_word();
      test_store_byte();
      test_half_same_cycle();
      test_done_stall();
      test_watchdog();
      test_misaligned();
      test_load_word();
      test_reset_mid_access();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
